// File: rtl/wishbone_stream_ctl.sv
// Wishbone slave bridging the management bus to the enclave core: host-to-core and
// core-to-host word FIFOs plus CONFIG, STATUS and CTRL registers with sticky error flags.
module wishbone_stream_ctl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned IN_DEPTH  = 8,
    parameter int unsigned OUT_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        in_valid,
    output logic [31:0] in_data,
    input  logic        in_ready,
    input  logic        out_valid,
    input  logic [31:0] out_data,
    output logic        out_ready,
    output logic        config_en,
    output logic [31:0] config_data,
    output logic        irq
);
    localparam int unsigned IAW = $clog2(IN_DEPTH);
    localparam int unsigned OAW = $clog2(OUT_DEPTH);
    localparam logic [IAW:0] IN_FULL_CNT  = IN_DEPTH[IAW:0];
    localparam logic [OAW:0] OUT_FULL_CNT = OUT_DEPTH[OAW:0];

    logic [31:0]  in_mem_q  [IN_DEPTH];
    logic [31:0]  out_mem_q [OUT_DEPTH];
    logic [IAW-1:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    logic [IAW:0]   in_cnt_q, in_cnt_d;
    logic [OAW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic [OAW:0]   out_cnt_q, out_cnt_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] config_q, config_d;
    logic        config_en_q, config_en_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        ovf_q, ovf_d, unf_q, unf_d, irq_q, irq_d;

    logic        hit_s, acc_s;
    logic        in_full_s, in_empty_s, out_full_s, out_empty_s;
    logic        in_push_s, in_pop_s, out_push_s, out_pop_s, flush_s;
    logic        ovf_set_s, ovf_clr_s, unf_set_s, unf_clr_s;
    logic [31:0] status_s;
    logic        unused_s;

    assign hit_s       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign acc_s       = hit_s & ~ack_q;
    assign in_full_s   = (in_cnt_q == IN_FULL_CNT);
    assign in_empty_s  = (in_cnt_q == {(IAW+1){1'b0}});
    assign out_full_s  = (out_cnt_q == OUT_FULL_CNT);
    assign out_empty_s = (out_cnt_q == {(OAW+1){1'b0}});
    assign in_pop_s    = in_ready & ~in_empty_s;
    assign out_push_s  = out_valid & ~out_full_s;
    assign status_s    = {6'b0, unf_q, ovf_q, 4'b0, out_empty_s, out_full_s, in_empty_s,
                          in_full_s, 8'(out_cnt_q), 8'(in_cnt_q)};
    assign unused_s    = ^wbs_adr_i[1:0];

    // Bus decode: one accepted transaction selects register access or FIFO operation
    always_comb begin
        dat_d       = dat_q;
        config_d    = config_q;
        config_en_d = 1'b0;
        ctrl_d      = ctrl_q;
        in_push_s   = 1'b0;
        out_pop_s   = 1'b0;
        flush_s     = 1'b0;
        ovf_set_s   = 1'b0;
        ovf_clr_s   = 1'b0;
        unf_set_s   = 1'b0;
        unf_clr_s   = 1'b0;
        if (acc_s) begin
            case (wbs_adr_i[3:2])
                2'd0: begin
                    if (wbs_we_i) begin
                        // A same-edge core pop frees the slot a full FIFO needs
                        if (~in_full_s | in_pop_s) begin
                            in_push_s = 1'b1;
                        end else begin
                            ovf_set_s = 1'b1;
                        end
                    end else if (out_empty_s) begin
                        dat_d     = 32'h0000_0000;
                        unf_set_s = 1'b1;
                    end else begin
                        dat_d     = out_mem_q[out_rd_q];
                        out_pop_s = 1'b1;
                    end
                end
                2'd1: begin
                    if (wbs_we_i) begin
                        ovf_clr_s = wbs_dat_i[24];
                        unf_clr_s = wbs_dat_i[25];
                    end else begin
                        dat_d = status_s;
                    end
                end
                2'd2: begin
                    if (wbs_we_i) begin
                        config_en_d = 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (wbs_sel_i[b]) begin
                                config_d[8*b +: 8] = wbs_dat_i[8*b +: 8];
                            end else begin
                                config_d[8*b +: 8] = config_q[8*b +: 8];
                            end
                        end
                    end else begin
                        dat_d = config_q;
                    end
                end
                2'd3: begin
                    if (wbs_we_i) begin
                        ctrl_d  = wbs_dat_i[1:0];
                        flush_s = wbs_dat_i[2];
                    end else begin
                        dat_d = {30'h0, ctrl_q};
                    end
                end
                default: begin
                    dat_d = dat_q;
                end
            endcase
        end else begin
            dat_d = dat_q;
        end
    end

    // FIFO pointer/count bookkeeping, sticky flags and interrupt source
    always_comb begin
        in_wr_d   = in_wr_q;
        in_rd_d   = in_rd_q;
        in_cnt_d  = in_cnt_q;
        out_wr_d  = out_wr_q;
        out_rd_d  = out_rd_q;
        out_cnt_d = out_cnt_q;
        if (flush_s) begin
            in_wr_d   = {IAW{1'b0}};
            in_rd_d   = {IAW{1'b0}};
            in_cnt_d  = {(IAW+1){1'b0}};
            out_wr_d  = {OAW{1'b0}};
            out_rd_d  = {OAW{1'b0}};
            out_cnt_d = {(OAW+1){1'b0}};
        end else begin
            if (in_push_s) in_wr_d = in_wr_q + IAW'(1'b1);
            else           in_wr_d = in_wr_q;
            if (in_pop_s)  in_rd_d = in_rd_q + IAW'(1'b1);
            else           in_rd_d = in_rd_q;
            if (out_push_s) out_wr_d = out_wr_q + OAW'(1'b1);
            else            out_wr_d = out_wr_q;
            if (out_pop_s)  out_rd_d = out_rd_q + OAW'(1'b1);
            else            out_rd_d = out_rd_q;
            case ({in_push_s, in_pop_s})
                2'b10:   in_cnt_d = in_cnt_q + (IAW+1)'(1'b1);
                2'b01:   in_cnt_d = in_cnt_q - (IAW+1)'(1'b1);
                default: in_cnt_d = in_cnt_q;
            endcase
            case ({out_push_s, out_pop_s})
                2'b10:   out_cnt_d = out_cnt_q + (OAW+1)'(1'b1);
                2'b01:   out_cnt_d = out_cnt_q - (OAW+1)'(1'b1);
                default: out_cnt_d = out_cnt_q;
            endcase
        end
        if (ovf_set_s)      ovf_d = 1'b1;
        else if (ovf_clr_s) ovf_d = 1'b0;
        else                ovf_d = ovf_q;
        if (unf_set_s)      unf_d = 1'b1;
        else if (unf_clr_s) unf_d = 1'b0;
        else                unf_d = unf_q;
        ack_d = acc_s;
        irq_d = (ctrl_q[0] & ~out_empty_s) | (ctrl_q[1] & (ovf_q | unf_q));
    end

    // Control and status state
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            in_wr_q     <= {IAW{1'b0}};
            in_rd_q     <= {IAW{1'b0}};
            in_cnt_q    <= {(IAW+1){1'b0}};
            out_wr_q    <= {OAW{1'b0}};
            out_rd_q    <= {OAW{1'b0}};
            out_cnt_q   <= {(OAW+1){1'b0}};
            ack_q       <= 1'b0;
            dat_q       <= 32'h0000_0000;
            config_q    <= 32'h0000_0000;
            config_en_q <= 1'b0;
            ctrl_q      <= 2'b00;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            in_wr_q     <= in_wr_d;
            in_rd_q     <= in_rd_d;
            in_cnt_q    <= in_cnt_d;
            out_wr_q    <= out_wr_d;
            out_rd_q    <= out_rd_d;
            out_cnt_q   <= out_cnt_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            config_q    <= config_d;
            config_en_q <= config_en_d;
            ctrl_q      <= ctrl_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            irq_q       <= irq_d;
        end
    end

    // FIFO storage; contents are meaningful only between the pointers
    always_ff @(posedge wb_clk_i) begin
        if (in_push_s & ~flush_s) begin
            in_mem_q[in_wr_q] <= wbs_dat_i;
        end
        if (out_push_s & ~flush_s) begin
            out_mem_q[out_wr_q] <= out_data;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign in_valid    = ~in_empty_s;
    assign in_data     = in_mem_q[in_rd_q];
    assign out_ready   = ~out_full_s;
    assign config_en   = config_en_q;
    assign config_data = config_q;
    assign irq         = irq_q;
endmodule

// File: tb/tb_wishbone_stream_ctl.sv
// Self-checking bench for wishbone_stream_ctl: directed steps plus a randomized phase
// checked against a queue-based model of the FIFOs, flags and interrupt.
module tb_wishbone_stream_ctl;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int IN_D  = 8;
    localparam int OUT_D = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic        in_valid, in_ready = 1'b0;
    logic [31:0] in_data;
    logic        out_valid = 1'b0, out_ready;
    logic [31:0] out_data = 32'h0;
    logic        config_en;
    logic [31:0] config_data;
    logic        irq;

    always #5 clk = ~clk;

    wishbone_stream_ctl #(.BASE_ADDR(BASE), .IN_DEPTH(IN_D), .OUT_DEPTH(OUT_D)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .config_en(config_en), .config_data(config_data), .irq(irq)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] in_q[$];
    logic [31:0] out_q[$];
    bit          ovf_m = 1'b0, unf_m = 1'b0;
    logic [1:0]  ctrl_m = 2'b00;
    logic [31:0] cfg_m = 32'h0;
    logic        last_cen;

    function automatic logic [31:0] model_status();
        return {6'b0, unf_m, ovf_m, 4'b0,
                out_q.size() == 0, out_q.size() == OUT_D,
                in_q.size() == 0, in_q.size() == IN_D,
                8'(out_q.size()), 8'(in_q.size())};
    endfunction

    function automatic logic model_irq();
        return (ctrl_m[0] && out_q.size() != 0) || (ctrl_m[1] && (ovf_m || unf_m));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One Wishbone transaction; optional core pop/push share the acceptance edge
    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input logic pop_en, input logic push_en,
                           input logic [31:0] push_w, output logic [31:0] r);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
        in_ready = pop_en; out_valid = push_en; out_data = push_w;
        @(posedge clk); #1;
        in_ready = 1'b0; out_valid = 1'b0;
        chk("ack_latency", {31'b0, ack}, 32'd1);
        r = rdat;
        last_cen = config_en;
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic bus_wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_xfer(BASE + {28'h0, off}, 1'b1, d, s, 1'b0, 1'b0, 32'h0, dummy);
    endtask

    task automatic bus_rd(input logic [3:0] off, output logic [31:0] d);
        wb_xfer(BASE + {28'h0, off}, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, d);
    endtask

    task automatic m_push_data(input logic [31:0] w);
        if (in_q.size() < IN_D) in_q.push_back(w);
        else ovf_m = 1'b1;
        bus_wr(4'h0, w, 4'hF);
    endtask

    task automatic m_read_data(input string tag);
        logic [31:0] exp, got;
        if (out_q.size() == 0) begin
            exp = 32'h0;
            unf_m = 1'b1;
        end else begin
            exp = out_q.pop_front();
        end
        bus_rd(4'h0, got);
        chk(tag, got, exp);
    endtask

    task automatic m_read_status(input string tag);
        logic [31:0] got;
        bus_rd(4'h4, got);
        chk(tag, got, model_status());
    endtask

    task automatic m_write_status(input logic [31:0] d);
        if (d[24]) ovf_m = 1'b0;
        if (d[25]) unf_m = 1'b0;
        bus_wr(4'h4, d, 4'hF);
    endtask

    task automatic m_write_ctrl(input logic [31:0] d);
        ctrl_m = d[1:0];
        if (d[2]) begin
            in_q.delete();
            out_q.delete();
        end
        bus_wr(4'hC, d, 4'hF);
    endtask

    task automatic core_push(input logic [31:0] w);
        @(negedge clk);
        chk("out_ready", {31'b0, out_ready}, {31'b0, out_q.size() < OUT_D});
        out_valid = 1'b1; out_data = w;
        @(posedge clk);
        if (out_q.size() < OUT_D) out_q.push_back(w);
        #1 out_valid = 1'b0;
    endtask

    task automatic core_pop();
        @(negedge clk);
        chk("in_valid", {31'b0, in_valid}, {31'b0, in_q.size() != 0});
        if (in_q.size() != 0) chk("in_data", in_data, in_q[0]);
        in_ready = 1'b1;
        @(posedge clk);
        if (in_q.size() != 0) void'(in_q.pop_front());
        #1 in_ready = 1'b0;
    endtask

    task automatic chk_irq(input string tag);
        @(posedge clk); #1;
        chk(tag, {31'b0, irq}, {31'b0, model_irq()});
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] stream_exp [3];
        logic        seen;
        stream_exp[0] = 32'h11; stream_exp[1] = 32'h22; stream_exp[2] = 32'h33;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_dat", rdat, 32'd0);
        chk("rst_in_valid", {31'b0, in_valid}, 32'd0);
        chk("rst_out_ready", {31'b0, out_ready}, 32'd1);
        chk("rst_config_en", {31'b0, config_en}, 32'd0);
        chk("rst_config", config_data, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        m_read_status("status_reset");

        // Three words queued, then streamed out on consecutive cycles
        m_push_data(32'h11); m_push_data(32'h22); m_push_data(32'h33);
        @(negedge clk) in_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("stream_valid", {31'b0, in_valid}, 32'd1);
            chk("stream_data", in_data, stream_exp[i]);
            @(negedge clk);
            void'(in_q.pop_front());
        end
        chk("stream_drained", {31'b0, in_valid}, 32'd0);
        in_ready = 1'b0;

        for (int i = 0; i < 9; i++) m_push_data(32'h100 + i);
        m_read_status("status_ovf");
        m_write_status(32'h0100_0000);
        m_read_status("status_ovf_clr");

        // Write to a full input FIFO together with a core pop: accepted, no overflow
        wb_xfer(BASE, 1'b1, 32'h55, 4'hF, 1'b1, 1'b0, 32'h0, got);
        void'(in_q.pop_front());
        in_q.push_back(32'h55);
        m_read_status("status_full_pop");
        core_pop();

        core_push(32'hC0DE_0001);
        core_push(32'hC0DE_0002);
        m_read_status("status_partial");
        // Flush with a simultaneous core push: push discarded
        wb_xfer(BASE + 32'hC, 1'b1, 32'h4, 4'hF, 1'b0, 1'b1, 32'hBAD0_BAD0, got);
        ctrl_m = 2'b00; in_q.delete(); out_q.delete();
        m_read_status("status_flush");
        chk("flush_in_valid", {31'b0, in_valid}, 32'd0);
        bus_rd(4'hC, got);
        chk("ctrl_flush_reads0", got, 32'd0);

        core_push(32'hA5A5_A5A5);
        m_write_ctrl(32'h1);
        chk_irq("irq_data");
        m_read_data("rd_a5");
        chk_irq("irq_data_clr");
        m_read_data("rd_unf");
        m_read_status("status_unf");
        m_write_ctrl(32'h2);
        chk_irq("irq_err");
        m_write_status(32'h0200_0000);
        chk_irq("irq_err_clr");
        bus_rd(4'hC, got);
        chk("ctrl_read", got, {30'b0, ctrl_m});

        // Read of empty output FIFO with a simultaneous core push
        wb_xfer(BASE, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 32'h77, got);
        chk("rd_empty_push", got, 32'h0);
        unf_m = 1'b1; out_q.push_back(32'h77);
        m_read_status("status_empty_push");
        m_read_data("rd_77");
        bus_wr(4'h4, 32'h0, 4'hF);
        chk("dat_hold", rdat, 32'h77);

        // CONFIG byte-lane write with strobe held through the ack cycle
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h8; wdat = 32'hDEAD_BEEF; sel = 4'b0011;
        @(posedge clk); #1;
        chk("cfg_ack", {31'b0, ack}, 32'd1);
        chk("cfg_en_pulse", {31'b0, config_en}, 32'd1);
        @(posedge clk); #1;
        chk("cfg_ack_drop", {31'b0, ack}, 32'd0);
        chk("cfg_en_drop", {31'b0, config_en}, 32'd0);
        cfg_m = 32'h0000_BEEF;
        chk("cfg_data", config_data, cfg_m);
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        bus_wr(4'h8, 32'h1234_5678, 4'h0);
        chk("cfg_en_sel0", {31'b0, last_cen}, 32'd1);
        bus_rd(4'h8, got);
        chk("cfg_read", got, cfg_m);

        // Out-of-window access is never acknowledged
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h10; wdat = 32'h99; sel = 4'hF;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack) seen = 1'b1;
        end
        chk("miss_no_ack", {31'b0, seen}, 32'd0);
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        m_read_status("status_after_miss");

        m_write_ctrl(32'h3);
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0, 1: m_push_data($urandom);
                2:    m_read_data("rnd_rd_data");
                3:    core_push($urandom);
                4:    core_pop();
                default: begin
                    if ($urandom_range(0, 1) == 0) m_read_status("rnd_status");
                    else m_write_status($urandom & 32'h0300_00FF);
                end
            endcase
            chk_irq("rnd_irq");
        end
        m_read_status("final_status");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
